// File: rtl/acc_window.sv
// Windowed accumulator: sums WINDOW accepted samples (or fewer on flush) and holds the total
// on a valid/ready output. Define ACC_SAT_EN to clamp the sum instead of wrapping it.
module acc_window #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned WINDOW    = 4,
  parameter int unsigned OUT_WIDTH = 10,
  localparam int unsigned CntW     = $clog2(WINDOW + 1)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [CntW-1:0]      out_count,
  output logic                 out_ovf
);

  localparam logic StAccum = 1'b0;
  localparam logic StEmit  = 1'b1;

  localparam logic [CntW-1:0] LastCnt = CntW'(WINDOW - 1);

  logic                 state_q, state_d;
  logic [OUT_WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 ovf_q, ovf_d;

  logic                 accept;
  logic [OUT_WIDTH:0]   sum_ext, data_ext, add_full;

  assign in_ready  = (state_q == StAccum);
  assign out_valid = (state_q == StEmit);
  assign out_data  = sum_q;
  assign out_count = count_q;
  assign out_ovf   = ovf_q;

  assign accept = in_valid && (state_q == StAccum);

  always_comb begin
    sum_ext                   = '0;
    sum_ext[OUT_WIDTH-1:0]    = sum_q;
    data_ext                  = '0;
    data_ext[WIDTH-1:0]       = in_data;
    add_full                  = sum_ext + data_ext;
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      StAccum: begin
        if (accept) begin
          count_d = count_q + CntW'(1);
          sum_d   = add_full[OUT_WIDTH-1:0];
          // Carry out of the top bit means the true sum no longer fits.
          if (add_full[OUT_WIDTH]) begin
            ovf_d = 1'b1;
`ifdef ACC_SAT_EN
            sum_d = '1;
`endif
          end
        end
        if ((accept && (count_q == LastCnt)) || (flush && ((count_q != '0) || accept))) begin
          state_d = StEmit;
        end
      end
      default: begin
        if (out_ready) begin
          state_d = StAccum;
          sum_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StAccum;
      sum_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_acc_window.sv
// Scoreboard bench for acc_window: a window-level model predicts each emitted total, and an
// independent monitor compares every presented output against the head of the queue.
module tb_acc_window;

  typedef struct {
    longint data;
    int     cnt;
    bit     ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, flush, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid, out_ovf;
  logic [9:0] out_data;
  logic [2:0] out_count;

  logic       in_valid8, flush8, out_ready8;
  logic [7:0] in_data8;
  logic       in_ready8, out_valid8, out_ovf8;
  logic [7:0] out_data8;
  logic [2:0] out_count8;

  int checks = 0;
  int errors = 0;

  exp_t   sb[$];
  longint win[$];
  bit     m_emit;

  always #5 clk = ~clk;

  acc_window dut (
    .CLK(clk), .RESET(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_ovf(out_ovf)
  );

  acc_window #(.WIDTH(8), .WINDOW(4), .OUT_WIDTH(8)) dut8 (
    .CLK(clk), .RESET(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .flush(flush8), .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .out_count(out_count8), .out_ovf(out_ovf8)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Window total from the raw sample list, using plain arithmetic.
  function automatic exp_t model(input longint s[$], input int ow);
    exp_t   e;
    longint total = 0;
    longint maxv  = (longint'(1) << ow) - 1;
    foreach (s[i]) total += s[i];
    e.cnt = s.size();
    e.ovf = (total > maxv);
`ifdef ACC_SAT_EN
    e.data = (total > maxv) ? maxv : total;
`else
    e.data = total % (maxv + 1);
`endif
    return e;
  endfunction

  // One cycle on the main DUT: drive, check handshake flags at negedge, advance the model.
  task automatic step(input bit v, input logic [7:0] d, input bit f, input bit r);
    in_valid = v; in_data = d; flush = f; out_ready = r;
    @(negedge clk);
    chk("in_ready", in_ready, !m_emit);
    chk("out_valid", out_valid, m_emit);
    if (!m_emit) begin
      if (v) win.push_back(longint'(d));
      if (win.size() == 4 || (f && win.size() > 0)) begin
        sb.push_back(model(win, 10));
        win.delete();
        m_emit = 1'b1;
      end
    end else if (r) begin
      m_emit = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid8 = 1'b0; flush8 = 1'b0; out_ready8 = 1'b0; in_data8 = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    win.delete();
    sb.delete();
    m_emit = 1'b0;
  endtask

  // Monitor: compare whatever the DUT presents against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          chk("out_data", out_data, sb[0].data);
          chk("out_count", out_count, sb[0].cnt);
          chk("out_ovf", out_ovf, sb[0].ovf);
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    exp_t e8;
    longint s8[$];
    bit seen;

    do_reset();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_ovf", out_ovf, 0);
    @(posedge clk);
    #1;

    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
    step(1'b0, 8'd0, 1'b0, 1'b1);
    step(1'b0, 8'd0, 1'b0, 1'b1);

    step(1'b1, 8'd5, 1'b0, 1'b1);
    step(1'b1, 8'd6, 1'b0, 1'b1);
    step(1'b0, 8'd0, 1'b1, 1'b1);
    step(1'b0, 8'd0, 1'b0, 1'b1);
    step(1'b0, 8'd0, 1'b1, 1'b1);
    step(1'b0, 8'd0, 1'b0, 1'b1);

    step(1'b1, 8'd7, 1'b0, 1'b1);
    step(1'b1, 8'd8, 1'b0, 1'b1);
    step(1'b1, 8'd9, 1'b1, 1'b1);
    step(1'b0, 8'd0, 1'b0, 1'b1);

    for (int i = 0; i < 4; i++) step(1'b1, 8'hff, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(i + 3), 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b1);
    step(1'b0, 8'd0, 1'b0, 1'b1);

    step(1'b1, 8'd50, 1'b0, 1'b1);
    step(1'b1, 8'd60, 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'd1, 1'b0, 1'b1);
    step(1'b0, 8'd0, 1'b0, 1'b1);

    // Narrow-output instance: 200+100+1+1 overflows 8 bits.
    s8 = '{200, 100, 1, 1};
    e8 = model(s8, 8);
    out_ready8 = 1'b1;
    foreach (s8[i]) begin
      in_valid8 = 1'b1; in_data8 = 8'(s8[i]);
      @(posedge clk);
      #1;
    end
    in_valid8 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      if (out_valid8) begin
        seen = 1'b1;
        chk("ow8_data", out_data8, e8.data);
        chk("ow8_count", out_count8, e8.cnt);
        chk("ow8_ovf", out_ovf8, e8.ovf);
      end
    end
    chk("ow8_output_seen", seen, 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) < 7);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'd0, 1'b0, 1'b1);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_window.md
# acc_window

Downstream consumer of the 8-bit incrementer stage output. Accepts a valid/ready stream of `WIDTH`-bit samples, sums each run of `WINDOW` consecutive accepted samples into an `OUT_WIDTH`-bit total, and presents the total on a valid/ready output. The total is held stable until the sink accepts it. A `flush` input closes a partial window early.

## Interface
Parameters:
- `WIDTH`, 8, input sample width
- `WINDOW`, 4, number of samples per full window (≥2)
- `OUT_WIDTH`, 10, accumulator/output width (≥`WIDTH`; may be smaller than `WIDTH+clog2(WINDOW)`)

Ports:
- `CLK` input 1: sole clock, rising edge
- `RESET` input 1: synchronous, active-high reset
- `in_valid` input 1: upstream sample valid
- `in_ready` output 1: block can accept a sample this cycle
- `in_data` input `WIDTH`: sample, unsigned
- `flush` input 1: close current partial window
- `out_valid` output 1: `out_data`, `out_count` and `out_ovf` are valid
- `out_ready` input 1: sink accepts output
- `out_data` output `OUT_WIDTH`: window sum
- `out_count` output `clog2(WINDOW+1)`: number of samples in the emitted window
- `out_ovf` output 1: sum exceeded `OUT_WIDTH` during this window

## Operation
- Two-state FSM: `ACCUM` and `EMIT`.
- `ACCUM`:
  - `in_ready`=1, `out_valid`=0.
  - On accept (`in_valid & in_ready`): `sum <= sum + in_data`, `count <= count+1`.
  - Overflow of the add sets sticky `ovf`.
- `ACCUM → EMIT` when either:
  - a sample is accepted with `count == WINDOW-1`, or
  - `flush`=1 and (`count>0` or a sample is accepted this cycle). A sample accepted in the flush cycle is included.
- `flush` in `ACCUM` with `count==0` and no accept is ignored.
- `EMIT`:
  - `in_ready`=0, `out_valid`=1.
  - `out_data`/`out_count`/`out_ovf` are the registered totals and stay stable.
  - `flush` is ignored.
- `EMIT → ACCUM` on `out_ready`=1; `sum`, `count` and `ovf` clear in the same edge.
- Arithmetic:
  - Unsigned. `in_data` is zero-extended to `OUT_WIDTH`.
  - Without `ACC_SAT_EN` the sum wraps modulo 2^`OUT_WIDTH`.
- Reset values:
  - State `ACCUM`; `sum`, `count`, `ovf` = 0.
  - `out_valid`=0, `out_data`=0, `out_count`=0, `out_ovf`=0, `in_ready`=1 on the first cycle after reset.
- Reset asserted mid-window or in `EMIT` discards the partial or pending result without emitting it. Reset has priority over every other input.

## Timing
- `in_ready` and `out_valid` are decoded directly from the state register. No combinational path exists from `out_ready` or `in_valid` to either signal.
- Latency: `out_valid` rises on the cycle after the closing sample is accepted.
- Throughput: at most one window per `WINDOW+1` cycles. There is always one bubble cycle (`in_ready`=0) per window.
- `out_ready` may be held high permanently. `EMIT` then lasts exactly one cycle.
- `out_ready` while `out_valid`=0 has no effect.
- `in_data` is sampled only on accept. `in_valid` may drop at any time without penalty.

## Configuration
- `ACC_SAT_EN` defined:
  - Any add whose true result exceeds 2^`OUT_WIDTH`-1 clamps `sum` to 2^`OUT_WIDTH`-1.
  - Further adds keep it clamped.
  - `out_ovf`=1.
- `ACC_SAT_EN` undefined:
  - The sum wraps.
  - `out_ovf` still reports that a wrap occurred.

## Test plan
- Reset, then samples 1,2,3,4 on consecutive cycles, `out_ready`=1 → one cycle after the 4th accept: `out_valid`=1, `out_data`=10, `out_count`=4, `out_ovf`=0. `in_ready`=0 for exactly that cycle.
- Samples 5,6, then `flush` alone → `out_data`=11, `out_count`=2. Then `flush` alone with the window empty → no output.
- Samples 7,8,9 with `flush` asserted in the same cycle as 9 → `out_data`=24, `out_count`=3.
- Full window of 0xFF×4 with `out_ready`=0 for 5 cycles → `out_valid`, `out_data`=1020 and `out_count`=4 stay stable all 5 cycles. `in_ready`=0 throughout. The window releases on the cycle `out_ready` goes high.
- `OUT_WIDTH`=8, samples 200,100,1,1:
  - without `ACC_SAT_EN` → `out_data`=46, `out_ovf`=1
  - with `ACC_SAT_EN` → `out_data`=255, `out_ovf`=1
- 2 samples accepted, then `RESET` for 1 cycle, then 1,1,1,1 → first output is `out_data`=4, `out_count`=4. No output emitted for the discarded partial window.
